// File: rtl/q_update_if.sv
// Request/result bundle between the max-Q stage, the Q-update unit and the Q-table write port.
// The slave modport is the update unit; the master modport is whoever drives requests and accepts writes.
interface q_update_if #(
  parameter int unsigned STATE_W = 15
);
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic [3:0]         in_action;
  logic [15:0]        q_old;
  logic [15:0]        reward;
  logic [15:0]        max_q;
  logic               terminal;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic [3:0]         out_action;
  logic [15:0]        q_new;
  logic               err_action;

  modport master (
    output in_valid, in_state, in_action, q_old, reward, max_q, terminal, out_ready,
    input  in_ready, out_valid, out_state, out_action, q_new, err_action
  );

  modport slave (
    input  in_valid, in_state, in_action, q_old, reward, max_q, terminal, out_ready,
    output in_ready, out_valid, out_state, out_action, q_new, err_action
  );
endinterface

// File: rtl/q_update_unit.sv
// Q-learning write-back: Q' = Q + 2^-ALPHA_SHIFT * (r + gamma*maxQ - Q), clamped to unsigned Q8.8.
// One request at a time through a five-state pipeline-free FSM; the result is held until the table accepts it.
module q_update_unit #(
  parameter logic [15:0] GAMMA       = 16'h00E6,
  parameter int unsigned ALPHA_SHIFT = 3
) (
  input logic       clk,
  input logic       rst,
  q_update_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL, ADD, UPD, HOLD} state_t;

  state_t state, state_nx;

  logic               accept;
  logic               bad_action;
  logic [15:0]        q_old_r;
  logic [15:0]        reward_r;
  logic [15:0]        max_q_r;
  logic               term_r;
  logic [23:0]        p_r;
  logic signed [26:0] td_r;

  logic [23:0]        p_nx;
  logic signed [25:0] target;
  logic signed [26:0] td_nx;
  logic signed [26:0] d;
  logic signed [27:0] sum;
  logic [15:0]        q_clamped;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign bad_action = bus.in_action > 4'd8;

  // NOTE: state and every register below use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && !bad_action) state_nx = MUL;
      end
      MUL:  state_nx = ADD;
      ADD:  state_nx = UPD;
      UPD:  state_nx = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Arithmetic: gamma product truncated to 24 bits, then signed TD error and floor-shifted step.
  always_comb begin
    p_nx   = term_r ? 24'd0 : 24'((32'(max_q_r) * 32'(GAMMA)) >> 8);
    target = {{10{reward_r[15]}}, reward_r} + {2'b00, p_r};
    td_nx  = {target[25], target} - {11'b0, q_old_r};
    d      = td_r >>> ALPHA_SHIFT;
    sum    = {d[26], d} + {12'b0, q_old_r};
    if (sum[27])           q_clamped = 16'h0000;
    else if (|sum[26:16])  q_clamped = 16'hFFFF;
    else                   q_clamped = sum[15:0];
  end

  // NOTE: datapath holding registers carry no reset; the FSM guarantees they are written before they are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_old_r  <= bus.q_old;
      reward_r <= bus.reward;
      max_q_r  <= bus.max_q;
      term_r   <= bus.terminal;
    end
    if (state == MUL) p_r  <= p_nx;
    if (state == ADD) td_r <= td_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_state  <= '0;
      bus.out_action <= '0;
      bus.q_new      <= '0;
      bus.err_action <= 1'b0;
    end else begin
      if (accept) begin
        if (bad_action) begin
          bus.err_action <= 1'b1;
        end else begin
          bus.out_state  <= bus.in_state;
          bus.out_action <= bus.in_action;
        end
      end
      if (state == UPD) bus.q_new <= q_clamped;
    end
  end

endmodule

// File: tb/tb_q_update_unit.sv
// Self-checking bench for q_update_unit: table of update vectors through a scoreboard,
// plus hand-written sequences for back-pressure, mid-operation reset and illegal actions.
module tb_q_update_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  q_update_if #(.STATE_W(15)) bus ();

  q_update_unit #(.GAMMA(16'h00E6), .ALPHA_SHIFT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [14:0] st;
    logic [3:0]  act;
    logic [15:0] q_old;
    logic [15:0] reward;
    logic [15:0] max_q;
    logic        term;
    logic [15:0] exp_q;
  } vec_t;

  typedef struct {
    logic [14:0] st;
    logic [3:0]  act;
    logic [15:0] q;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("in_ready timeout", 32'(n), 32'd0);
    bus.in_state  = v.st;
    bus.in_action = v.act;
    bus.q_old     = v.q_old;
    bus.reward    = v.reward;
    bus.max_q     = v.max_q;
    bus.terminal  = v.term;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Sends one request, checks latency, holds back-pressure for hold cycles, then completes the write.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    exp_t e;
    int   cnt = 0;
    drive_req(v);
    sb.push_back('{st: v.st, act: v.act, q: v.exp_q});
    @(negedge clk);
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, 32'(cnt), 32'd3);
    e = sb.pop_front();
    check({tag, " q_new"}, 32'(bus.q_new), 32'(e.q));
    check({tag, " out_state"}, 32'(bus.out_state), 32'(e.st));
    check({tag, " out_action"}, 32'(bus.out_action), 32'(e.act));
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus.in_valid  = 1'b1;
        bus.in_state  = 15'h1ABC;
        bus.in_action = 4'd1;
        bus.q_old     = 16'h1111;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, " hold q_new"}, 32'(bus.q_new), 32'(e.q));
      check({tag, " hold out_state"}, 32'(bus.out_state), 32'(e.st));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, " done out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " done in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check({tag, " no out_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    vec_t v;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_action = '0;
    bus.q_old     = '0;
    bus.reward    = '0;
    bus.max_q     = '0;
    bus.terminal  = 1'b0;
    bus.out_ready = 1'b0;

    //           st        act   q_old     reward    max_q     term  exp_q
    vecs[0] = '{15'h0001, 4'd0, 16'h0000, 16'h0100, 16'h0000, 1'b0, 16'h0020};
    vecs[1] = '{15'h0002, 4'd4, 16'h0200, 16'h0000, 16'h0400, 1'b0, 16'h0233};
    vecs[2] = '{15'h4CE3, 4'd8, 16'h0010, 16'hFF00, 16'hFFFF, 1'b1, 16'h0000};
    vecs[3] = '{15'h7FFF, 4'd7, 16'hFFF0, 16'h7FFF, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[4] = '{15'h0123, 4'd2, 16'h0100, 16'hFF80, 16'h0100, 1'b0, 16'h00EC};
    vecs[5] = '{15'h0456, 4'd3, 16'h0080, 16'h0200, 16'h1234, 1'b1, 16'h00B0};
    vecs[6] = '{15'h0789, 4'd5, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{15'h2222, 4'd6, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'hFCBF};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_state", 32'(bus.out_state), 32'd0);
    check("reset out_action", 32'(bus.out_action), 32'd0);
    check("reset q_new", 32'(bus.q_new), 32'd0);
    check("reset err_action", 32'(bus.err_action), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Back-pressure: six cycles of out_ready=0 with a stray request in the middle.
    run_vec(vecs[1], 6, "backpressure");
    expect_quiet(6, "stray request");

    // Reset while the unit is in ADD discards the pending update.
    drive_req(vecs[0]);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset q_new", 32'(bus.q_new), 32'd0);
    expect_quiet(6, "midreset");

    // Illegal action sets the sticky error and produces no write.
    v = vecs[1];
    v.act = 4'd9;
    drive_req(v);
    @(negedge clk);
    check("bad action err", 32'(bus.err_action), 32'd1);
    check("bad action in_ready", 32'(bus.in_ready), 32'd1);
    expect_quiet(6, "bad action");
    run_vec(vecs[4], 0, "after bad");
    check("err sticky", 32'(bus.err_action), 32'd1);

    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("err cleared by rst", 32'(bus.err_action), 32'd0);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
